// File: rtl/st7735_sink_if.sv
// SPI-side pins of the ST7735 4-wire display link, as driven by the st7735 driver.
// The master drives the pins and the slave (the sink) samples them.
interface st7735_sink_if;
  logic oled_cs;
  logic oled_clk;
  logic oled_mosi;
  logic oled_dc;
  logic disp_reset;

  modport master (
    output oled_cs,
    output oled_clk,
    output oled_mosi,
    output oled_dc,
    output disp_reset
  );

  modport slave (
    input oled_cs,
    input oled_clk,
    input oled_mosi,
    input oled_dc,
    input disp_reset
  );
endinterface

// File: rtl/st7735_sink.sv
// Receive-side model of the ST7735 SPI link: rebuilds bytes, tracks CASET/RASET/RAMWR
// and emits one (x, y, color) write per received pixel.
module st7735_sink #(
  parameter int C_color_bits = 16,
  parameter int C_x_size     = 128,
  parameter int C_y_size     = 160
) (
  input  logic                    clk,
  input  logic                    reset,
  st7735_sink_if.slave            spi,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    pix_valid,
  output logic [7:0]              pix_x,
  output logic [7:0]              pix_y,
  output logic [C_color_bits-1:0] pix_color
);

  localparam logic [7:0] XE_DEF = 8'(C_x_size - 1);
  localparam logic [7:0] YE_DEF = 8'(C_y_size - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CASET  = 3'd1,
    ST_RASET  = 3'd2,
    ST_RAMWR  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // pin bundle order: {disp_reset, dc, mosi, clk, cs}
  logic [4:0] pins_s;
  logic [4:0] sync1_r;
  logic [4:0] sync2_r;
  logic       panel_rst_s;

  logic       clk_d_r;
  logic       edge_r;
  logic       cs_e_r;
  logic       cs_p_r;
  logic       mosi_e_r;
  logic       dc_e_r;
  logic       take_bit_s;

  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] byte_r;
  logic       byte_dc_r;
  logic       byte_done_r;

  state_t     state_r;
  state_t     state_nx_s;
  logic       is_cmd_s;
  logic       is_data_s;
  logic       pix_done_s;

  logic [7:0] xs_r;
  logic [7:0] xe_r;
  logic [7:0] ys_r;
  logic [7:0] ye_r;
  logic [7:0] start_tmp_r;
  logic [2:0] param_cnt_r;
  logic [7:0] x_ptr_r;
  logic [7:0] y_ptr_r;
  logic [7:0] x_nx_s;
  logic [7:0] y_nx_s;
  logic       half_r;
  logic [7:0] hi_r;
  logic [15:0] color16_s;

  logic                    cmd_valid_r;
  logic [7:0]              cmd_byte_r;
  logic                    pix_valid_r;
  logic [7:0]              pix_x_r;
  logic [7:0]              pix_y_r;
  logic [C_color_bits-1:0] pix_color_r;

  assign pins_s      = {spi.disp_reset, spi.oled_dc, spi.oled_mosi, spi.oled_clk, spi.oled_cs};
  assign panel_rst_s = ~sync2_r[4];

  // Two-flop synchronizer for every link pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
    end else begin
      sync1_r <= pins_s;
      sync2_r <= sync1_r;
    end
  end

  // Rising-edge detect on oled_clk, with cs/mosi/dc delayed to stay aligned with the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_d_r  <= 1'b0;
      edge_r   <= 1'b0;
      cs_e_r   <= 1'b0;
      cs_p_r   <= 1'b0;
      mosi_e_r <= 1'b0;
      dc_e_r   <= 1'b0;
    end else begin
      clk_d_r  <= sync2_r[1];
      edge_r   <= sync2_r[1] & ~clk_d_r;
      cs_e_r   <= sync2_r[0];
      cs_p_r   <= cs_e_r;
      mosi_e_r <= sync2_r[2];
      dc_e_r   <= sync2_r[3];
    end
  end

  // A bit whose clock edge coincides with cs rising still counts; cs must have been low just before.
  assign take_bit_s = edge_r & ~(cs_e_r & cs_p_r);

  // Serial-to-parallel byte assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r     <= 7'd0;
      bit_cnt_r   <= 3'd0;
      byte_r      <= 8'd0;
      byte_dc_r   <= 1'b0;
      byte_done_r <= 1'b0;
    end else if (panel_rst_s) begin
      bit_cnt_r   <= 3'd0;
      byte_done_r <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      if (take_bit_s) begin
        shift_r   <= {shift_r[5:0], mosi_e_r};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_r      <= {shift_r, mosi_e_r};
          byte_dc_r   <= dc_e_r;
          byte_done_r <= 1'b1;
        end
      end else if (cs_e_r) begin
        bit_cnt_r <= 3'd0;
      end
    end
  end

  // Parser state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode plus pixel-completion and pointer-advance terms.
  always_comb begin
    state_nx_s = state_r;
    is_cmd_s   = byte_done_r & ~byte_dc_r;
    is_data_s  = byte_done_r & byte_dc_r;
    pix_done_s = 1'b0;
    x_nx_s     = x_ptr_r;
    y_nx_s     = y_ptr_r;
    color16_s  = 16'h0000;

    if (panel_rst_s) begin
      state_nx_s = ST_IDLE;
    end else if (is_cmd_s) begin
      case (byte_r)
        8'h2A:   state_nx_s = ST_CASET;
        8'h2B:   state_nx_s = ST_RASET;
        8'h2C:   state_nx_s = ST_RAMWR;
        default: state_nx_s = ST_IGNORE;
      endcase
    end else begin
      state_nx_s = state_r;
    end

    if (is_data_s && (state_r == ST_RAMWR)) begin
      pix_done_s = (C_color_bits != 16) | half_r;
    end else begin
      pix_done_s = 1'b0;
    end

    if (C_color_bits == 16) begin
      color16_s = {hi_r, byte_r};
    end else begin
      color16_s = {8'h00, byte_r};
    end

    if (x_ptr_r == xe_r) begin
      x_nx_s = xs_r;
      if (y_ptr_r == ye_r) begin
        y_nx_s = ys_r;
      end else begin
        y_nx_s = y_ptr_r + 8'd1;
      end
    end else begin
      x_nx_s = x_ptr_r + 8'd1;
      y_nx_s = y_ptr_r;
    end
  end

  // Window registers, write pointer and the registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xs_r        <= 8'd0;
      xe_r        <= XE_DEF;
      ys_r        <= 8'd0;
      ye_r        <= YE_DEF;
      start_tmp_r <= 8'd0;
      param_cnt_r <= 3'd0;
      x_ptr_r     <= 8'd0;
      y_ptr_r     <= 8'd0;
      half_r      <= 1'b0;
      hi_r        <= 8'd0;
      cmd_valid_r <= 1'b0;
      cmd_byte_r  <= 8'd0;
      pix_valid_r <= 1'b0;
      pix_x_r     <= 8'd0;
      pix_y_r     <= 8'd0;
      pix_color_r <= '0;
    end else begin
      cmd_valid_r <= 1'b0;
      pix_valid_r <= 1'b0;
      if (panel_rst_s) begin
        xs_r        <= 8'd0;
        xe_r        <= XE_DEF;
        ys_r        <= 8'd0;
        ye_r        <= YE_DEF;
        param_cnt_r <= 3'd0;
        half_r      <= 1'b0;
      end else if (is_cmd_s) begin
        cmd_valid_r <= 1'b1;
        cmd_byte_r  <= byte_r;
        param_cnt_r <= 3'd0;
        half_r      <= 1'b0;
        if (byte_r == 8'h2C) begin
          x_ptr_r <= xs_r;
          y_ptr_r <= ys_r;
        end
      end else if (is_data_s) begin
        case (state_r)
          ST_CASET, ST_RASET: begin
            if (param_cnt_r != 3'd4) begin
              param_cnt_r <= param_cnt_r + 3'd1;
            end
            if (param_cnt_r == 3'd1) begin
              start_tmp_r <= byte_r;
            end else if (param_cnt_r == 3'd3) begin
              if (state_r == ST_CASET) begin
                xs_r <= start_tmp_r;
                xe_r <= byte_r;
              end else begin
                ys_r <= start_tmp_r;
                ye_r <= byte_r;
              end
            end
          end
          ST_RAMWR: begin
            if (pix_done_s) begin
              pix_valid_r <= 1'b1;
              pix_x_r     <= x_ptr_r;
              pix_y_r     <= y_ptr_r;
              pix_color_r <= color16_s[C_color_bits-1:0];
              x_ptr_r     <= x_nx_s;
              y_ptr_r     <= y_nx_s;
              half_r      <= 1'b0;
            end else begin
              hi_r   <= byte_r;
              half_r <= 1'b1;
            end
          end
          default: begin
            half_r <= half_r;
          end
        endcase
      end
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_byte  = cmd_byte_r;
  assign pix_valid = pix_valid_r;
  assign pix_x     = pix_x_r;
  assign pix_y     = pix_y_r;
  assign pix_color = pix_color_r;

endmodule

// File: doc/st7735_sink.md
# st7735_sink

Receive-side model of the ST7735 4-wire SPI display link: samples oled_cs/oled_clk/oled_mosi/oled_dc as driven by the st7735 driver, reassembles bytes, interprets the window and RAM-write commands, and emits one pixel write (x, y, color) per received pixel. It sits in simulation benches and on-chip loopback designs in place of the physical panel, feeding a framebuffer or a checker.

## Interface
- C_color_bits, 16: pixel width; 16 means two bytes per pixel, MSB first; 8 means one byte per pixel.
- C_x_size, 128: default column count after reset.
- C_y_size, 160: default row count after reset.

- clk  input  1  system clock; must run at least 4× the oled_clk toggle rate.
- reset  input  1  asynchronous, active-low reset.
- oled_cs  input  1  chip select, active low.
- oled_clk  input  1  SPI clock; MOSI is sampled on its rising edge.
- oled_mosi  input  1  serial data, MSB first.
- oled_dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- disp_reset  input  1  panel hardware reset from the driver, active low.
- cmd_valid  output  1  one-cycle pulse per received command byte.
- cmd_byte  output  8  last command byte; valid when cmd_valid is high.
- pix_valid  output  1  one-cycle pulse per completed pixel.
- pix_x  output  8  column of the pixel; valid with pix_valid.
- pix_y  output  8  row of the pixel; valid with pix_valid.
- pix_color  output  C_color_bits  pixel value; valid with pix_valid.

## Operation
- Input sync: oled_cs, oled_clk, oled_mosi, oled_dc each pass through a 2-flop synchronizer. A rising edge is detected by comparing the synchronized oled_clk with its previous value.
- Bit assembly: on each detected edge with oled_cs low, shift mosi into an 8-bit shift register and increment a 3-bit counter. On the 8th bit, latch the byte and the dc value.
- oled_cs high clears the bit counter. A partial byte is discarded. Command state is kept.
- Parser states:
  - IDLE.
  - CASET_P: entered on command 0x2A; counts params 0..3.
  - RASET_P: entered on command 0x2B; counts params 0..3.
  - RAMWR: entered on command 0x2C.
  - IGNORE: entered on any other command.
- Any command byte (dc=0) pulses cmd_valid and jumps to the state for that command from any state.
- CASET and RASET parameters:
  - Params are XS_hi, XS_lo, XE_hi, XE_lo (and the same order for Y).
  - Only the low bytes are used; the high bytes are ignored.
  - The window registers update only on the 4th param. If fewer than 4 params arrive before the next command, they are discarded.
  - Extra params beyond the 4th are ignored.
- RAMWR:
  - Entering the state loads the pointer to (XS, YS) and clears the half-pixel flag.
  - For C_color_bits = 16: the first data byte is stored as the high byte; the second completes the pixel.
  - For C_color_bits = 8: each byte is one pixel.
  - On each completed pixel, pulse pix_valid with the current pointer, then advance.
  - Advance rule: if x == XE, set x = XS and advance y; otherwise x = x + 1 (8-bit wrap).
  - Y advance rule: if y == YE, set y = YS; otherwise y = y + 1 (8-bit wrap).
  - XS > XE is legal: x counts modulo 256 until it reaches XE.
  - A command arriving after an odd byte drops the half pixel.
- Data bytes in IDLE or IGNORE are dropped.
- disp_reset low, sampled synchronously after the synchronizer:
  - state = IDLE, window = defaults, bit counter = 0.
  - No pulses are generated while it is low.
- Window defaults: XS = 0, XE = C_x_size-1, YS = 0, YE = C_y_size-1.

## Timing
- Reset (async, reset low): all outputs are 0. Synchronizers, counters and pointer are cleared. Window = defaults. State = IDLE.
- Latency: pix_valid or cmd_valid goes high exactly 4 clk after the clk edge at which the pin-level oled_clk rise of the last bit is first captured:
  - 2 synchronizer cycles.
  - 1 edge-detect cycle.
  - 1 output register cycle.
- Pulses are exactly 1 cycle wide. pix_x, pix_y, pix_color and cmd_byte hold their value until the next pulse.
- At most one pulse per 8 SPI bits, so cmd_valid and pix_valid are never high together.
- A window update from the 4th param applies to a RAMWR command that follows immediately.
- oled_cs rising in the same clk as the 8th edge is detected: the byte completes. Bit-counter clearing takes effect after the byte is latched.
- reset asserted mid-byte or mid-pixel: everything clears immediately, and no pulse is produced for the partial data.

## Test plan
- Reset, then cs low, command 0x2C, data 0xF8 0x00 ×3 at 16-bit -> three pix_valid pulses: (0,0), (1,0), (2,0), each with color 0xF800; cmd_valid once with 0x2C.
- CASET 00 10 00 12, RASET 00 05 00 06, RAMWR, then 7 pixels -> coordinates (16,5), (17,5), (18,5), (16,6), (17,6), (18,6), (16,5).
- CASET with only 2 params, then RAMWR and one pixel -> pixel at (0,0); window unchanged.
- cs raised after 5 bits, then a full 0x2C byte -> only the full byte registers (cmd_valid with 0x2C); no spurious pulse.
- RAMWR, one data byte, then command 0x00, then RAMWR and pixel 0x1234 -> exactly one pix_valid at (0,0) with color 0x1234; cmd_valid for 0x00 and for 0x2C.
- Drive disp_reset low mid-stream after a CASET, then RAMWR and one pixel -> pixel at (0,0); measured latency from the last SPI edge is 4 clk.
